// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Central stall/flush sequencer for the 5-stage pipeline. It drives the write
// enables and flushes of the PC and the IF/ID, ID/EX and EX/MEM registers.
// It handles load-use stalls, branch/jump flushes, the mul/div busy interlock
// and the exception/interrupt redirect.
//
// Parameters:
//   MULDIV_CYCLES  latency of a mul/div operation in cycles (2..255)
//
// Optional feature macro:
//   HAZ_PERF_CNT_EN  when defined, stall_count counts every cycle with PC_Wr=0.
//                    When undefined, stall_count is tied to 0.
//
// Ports:
//   clk, reset          clock; synchronous active-low reset
//   ID_rs, ID_rt        register fields of the instruction held in IF/ID
//   ID_uses_rt          the ID instruction reads rt
//   ID_jump             a jump is resolved in ID
//   ID_muldiv_start     the ID instruction is mult/multu/div/divu
//   ID_mfhilo           the ID instruction is mfhi/mflo
//   EX_MemRead, EX_rt   a load is in EX, and its destination register
//   EX_branch_taken     a branch was resolved taken in EX
//   exc                 exception from the EX instruction (one-cycle pulse)
//   irq                 external interrupt (level)
//   PC_Wr, IF_ID_Wr     write enables for the PC and IF/ID
//   IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush   register flush controls
//   exc_vec_sel         the PC mux selects the exception vector
//   muldiv_busy         a mul/div operation is in progress
//   stall_count         performance counter of stall cycles
module pipe_hazard_ctrl #(
   parameter int MULDIV_CYCLES = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  ID_rs,
   input  logic [4:0]  ID_rt,
   input  logic        ID_uses_rt,
   input  logic        ID_jump,
   input  logic        ID_muldiv_start,
   input  logic        ID_mfhilo,
   input  logic        EX_MemRead,
   input  logic [4:0]  EX_rt,
   input  logic        EX_branch_taken,
   input  logic        exc,
   input  logic        irq,
   output logic        PC_Wr,
   output logic        IF_ID_Wr,
   output logic        IF_ID_Flush,
   output logic        ID_EX_Flush,
   output logic        EX_MEM_Flush,
   output logic        exc_vec_sel,
   output logic        muldiv_busy,
   output logic [31:0] stall_count
);

   typedef enum logic {RUN, MD_BUSY} state_t;

   state_t     state, state_next;
   logic [7:0] md_cnt, md_cnt_next;
   logic       irq_pend, irq_pend_next;
   logic       load_use, md_hazard, take_irq;

   // An r0 destination never creates a dependency, so a load into r0 never stalls.
   // A pending interrupt waits until no stall or branch flush is in progress.
   always_comb begin
      load_use  = EX_MemRead && (EX_rt != 5'd0) &&
                  ((EX_rt == ID_rs) || (ID_uses_rt && (EX_rt == ID_rt)));
      md_hazard = (state == MD_BUSY) && (ID_mfhilo || ID_muldiv_start);
      take_irq  = irq_pend && (state == RUN) && !load_use && !EX_branch_taken;
   end

   // The checks below run in priority order: redirect, branch flush, stall,
   // then jump. A mul/div that is in flight keeps counting down through branch
   // flushes and stalls. Only the exception/interrupt redirect aborts it.
   // Reset overrides the outputs last, so the pipeline is held flushed while
   // reset is low.
   always_comb begin
      PC_Wr         = 1'b1;
      IF_ID_Wr      = 1'b1;
      IF_ID_Flush   = 1'b0;
      ID_EX_Flush   = 1'b0;
      EX_MEM_Flush  = 1'b0;
      exc_vec_sel   = 1'b0;
      state_next    = state;
      md_cnt_next   = md_cnt;
      irq_pend_next = irq_pend | irq;

      if (exc || take_irq) begin
         IF_ID_Flush  = 1'b1;
         ID_EX_Flush  = 1'b1;
         EX_MEM_Flush = 1'b1;
         exc_vec_sel  = 1'b1;
         state_next   = RUN;
         md_cnt_next  = 8'd0;
         if (take_irq) begin
            irq_pend_next = 1'b0;
         end
      end else begin
         if (state == MD_BUSY) begin
            if (md_cnt == 8'd0) begin
               state_next = RUN;
            end else begin
               md_cnt_next = md_cnt - 8'd1;
            end
         end

         if (EX_branch_taken) begin
            IF_ID_Flush = 1'b1;
            ID_EX_Flush = 1'b1;
         end else if (load_use || md_hazard) begin
            PC_Wr       = 1'b0;
            IF_ID_Wr    = 1'b0;
            ID_EX_Flush = 1'b1;
         end else begin
            if ((state == RUN) && ID_muldiv_start) begin
               md_cnt_next = 8'(MULDIV_CYCLES - 1);
               state_next  = MD_BUSY;
            end
            if (ID_jump) begin
               IF_ID_Flush = 1'b1;
            end
         end
      end

      if (!reset) begin
         PC_Wr        = 1'b0;
         IF_ID_Wr     = 1'b0;
         IF_ID_Flush  = 1'b1;
         ID_EX_Flush  = 1'b1;
         EX_MEM_Flush = 1'b1;
         exc_vec_sel  = 1'b0;
      end
   end

   assign muldiv_busy = reset && (state == MD_BUSY);

   // Sequencer state register
   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= RUN;
         md_cnt   <= 8'd0;
         irq_pend <= 1'b0;
      end else begin
         state    <= state_next;
         md_cnt   <= md_cnt_next;
         irq_pend <= irq_pend_next;
      end
   end

`ifdef HAZ_PERF_CNT_EN
   // Count every cycle in which the PC is held. The counter wraps.
   always_ff @(posedge clk) begin
      if (!reset) begin
         stall_count <= 32'd0;
      end else if (!PC_Wr) begin
         stall_count <= stall_count + 32'd1;
      end
   end
`else
   assign stall_count = 32'd0;
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline. Drives the write-enable and flush controls of the PC, the IF/ID register and the downstream ID/EX and EX/MEM registers. Inputs are the decoded register fields held in IF/ID, EX-stage load and branch status, a multi-cycle mul/div unit, and exception/interrupt requests. Handles load-use stalls, control-flow flushes, mul/div busy interlock and exception redirect.

Parameters:
MULDIV_CYCLES, 32, latency of a mul/div op in cycles (range 2..255)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low
ID_rs  in  5  rs field of the instruction in IF/ID
ID_rt  in  5  rt field of the instruction in IF/ID
ID_uses_rt  in  1  instruction in ID reads rt
ID_jump  in  1  j/jal/jr resolved in ID
ID_muldiv_start  in  1  instruction in ID is mult/multu/div/divu
ID_mfhilo  in  1  instruction in ID is mfhi/mflo
EX_MemRead  in  1  instruction in EX is a load
EX_rt  in  5  destination of the load in EX
EX_branch_taken  in  1  branch resolved taken in EX
exc  in  1  exception raised by the instruction in EX (single-cycle pulse)
irq  in  1  external interrupt, level
PC_Wr  out  1  PC write enable
IF_ID_Wr  out  1  IF/ID write enable
IF_ID_Flush  out  1  clear IF/ID
ID_EX_Flush  out  1  insert bubble into ID/EX
EX_MEM_Flush  out  1  squash EX/MEM
exc_vec_sel  out  1  PC mux selects the exception vector
muldiv_busy  out  1  mul/div in progress
stall_count  out  32  perf counter (see Optional Feature)

Behaviour:
- FSM states: RUN, MD_BUSY. Registers: state, md_cnt[7:0], irq_pend.
- While reset=0 (sampled at posedge): state<=RUN, md_cnt<=0, irq_pend<=0. Outputs while reset=0: PC_Wr=0, IF_ID_Wr=0, IF_ID_Flush=1, ID_EX_Flush=1, EX_MEM_Flush=1, exc_vec_sel=0, muldiv_busy=0.
- Default outputs: PC_Wr=1, IF_ID_Wr=1, all flushes 0, exc_vec_sel=0.
- load_use = EX_MemRead & EX_rt!=0 & (EX_rt==ID_rs | (ID_uses_rt & EX_rt==ID_rt)).
- md_hazard = state==MD_BUSY & (ID_mfhilo | ID_muldiv_start).
- take_irq = irq_pend & state==RUN & !load_use & !EX_branch_taken.
- Priority per cycle, all decisions combinational and same cycle:
  1. exc | take_irq: IF_ID_Flush=ID_EX_Flush=EX_MEM_Flush=1, exc_vec_sel=1, PC_Wr=1. Next state=RUN, md_cnt<=0 (mul/div aborted). irq_pend<=0 if take_irq.
  2. EX_branch_taken: IF_ID_Flush=1, ID_EX_Flush=1, PC_Wr=1. A simultaneous load_use is ignored.
  3. load_use | md_hazard: PC_Wr=0, IF_ID_Wr=0, ID_EX_Flush=1. ID_jump is not honoured this cycle; it is re-evaluated after the stall.
  4. ID_jump: IF_ID_Flush=1.
- irq_pend<=1 whenever irq=1 and it is not being taken this cycle.
- Mul/div start:
  - In RUN, with ID_muldiv_start and no higher-priority case active: md_cnt<=MULDIV_CYCLES-1, state<=MD_BUSY.
  - In MD_BUSY: md_cnt decrements each cycle. When md_cnt==0, state<=RUN next cycle.
- muldiv_busy = (state==MD_BUSY).
- An mfhi/mflo in ID on the cycle MD_BUSY returns to RUN still stalls that cycle and proceeds on the next.

Optional Feature:
HAZ_PERF_CNT_EN
- Defined: stall_count is a 32-bit register. Reset to 0 while reset=0; otherwise increments (wrapping) every cycle PC_Wr=0.
- Undefined: stall_count is driven constant 0; no counter register exists.

Test Plan:
- Load-use: EX_MemRead=1, EX_rt=8, ID_rs=8 → for exactly 1 cycle PC_Wr=0, IF_ID_Wr=0, ID_EX_Flush=1. Repeat with EX_rt=0 → no stall.
- Branch and load-use together: EX_branch_taken=1 with the load-use condition true → IF_ID_Flush=1, ID_EX_Flush=1, PC_Wr=1.
- MULDIV_CYCLES=4:
  - mult in ID → muldiv_busy high for 4 cycles.
  - mflo presented in cycle 2 → stalled (PC_Wr=0) until muldiv_busy falls, then proceeds.
  - An unrelated add during busy is not stalled.
- Exception during mul/div: exc=1 in MD_BUSY → all three flushes and exc_vec_sel=1 in the same cycle; muldiv_busy=0 on the next cycle.
- irq held high during a load-use stall → not taken during the stall; taken on the first clean RUN cycle with all flushes=1; irq_pend cleared after.
- Reset mid-MD_BUSY: reset=0 for 1 cycle → muldiv_busy=0 and state RUN. With HAZ_PERF_CNT_EN, stall_count=0 after reset and equals 3 after three stall cycles.
